// File: rtl/fpga_config_loader_if.sv
// Serial configuration link between a bitstream source and the config loader.
//   start      : 1-cycle pulse, begin (or restart) a load
//   bit_in     : serial payload/CRC bit
//   bit_valid  : bit_in is valid this cycle
//   bit_ready  : loader takes a bit this cycle (function of loader state only)
// master = bitstream source, slave = loader.
interface fpga_config_loader_if;
   logic start;
   logic bit_in;
   logic bit_valid;
   logic bit_ready;

   modport master (output start, output bit_in, output bit_valid, input bit_ready);
   modport slave  (input start, input bit_in, input bit_valid, output bit_ready);
endinterface

// File: rtl/fpga_config_loader.sv
// Configuration loader for the 3x3 fabric. Shifts 891 config bits (stream bit k -> shadow[k])
// plus a CRC-8 trailer (MSB first) into a shadow register. If the received CRC matches the
// CRC computed over the payload, the shadow is committed in one cycle to the registered fabric
// config outputs, so the fabric never sees a partial configuration.
// Ports:
//   clk, reset           : clock; synchronous active-low reset
//   ctrl (slave)         : start / bit_in / bit_valid / bit_ready serial link
//   busy                 : load in progress (shift, CRC or commit)
//   done                 : 1-cycle pulse when a new config is committed
//   err                  : CRC mismatch, held until next start or reset
//   cfg_loaded           : sticky, at least one commit since reset
//   BLE_dff_select .. sel_direction : committed config fields
module fpga_config_loader #(
   parameter int unsigned CFG_BITS = 891,
   parameter int unsigned CRC_W    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   fpga_config_loader_if.slave   ctrl,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  cfg_loaded,
   output logic [8:0]            BLE_dff_select,
   output logic [3:0]            IO_sel,
   output logic [19:0]           IO_in,
   output logic [143:0]          LUT_in,
   output logic [239:0]          SB_in,
   output logic [419:0]          CB_in,
   output logic [35:0]           sel_direction_BLEout,
   output logic [17:0]           sel_direction
);

   localparam logic [9:0] LastData = 10'(CFG_BITS - 1);
   localparam logic [9:0] LastCrc  = 10'(CRC_W - 1);
   localparam logic [CRC_W-1:0] CrcPoly = CRC_W'(8'h07);

   typedef enum logic [2:0] {StIdle, StShift, StCrc, StCommit, StErr} state_e;

   state_e               state_q, state_d;
   logic [9:0]           cnt_q, cnt_d;
   logic [CRC_W-1:0]     crc_q, crc_d;
   logic [CRC_W-1:0]     rx_crc_q, rx_crc_d;
   logic [CFG_BITS-1:0]  shadow_q, shadow_d;
   logic [CFG_BITS-1:0]  cfg_q, cfg_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 cfg_loaded_q, cfg_loaded_d;

   logic                 bit_ready;
   logic                 accept;
   logic [CRC_W-1:0]     rx_crc_next;
   logic                 crc_match;

   // start wins over a simultaneous bit: the bit is dropped, not taken.
   assign accept      = ctrl.bit_valid && bit_ready && !ctrl.start;
   assign rx_crc_next = {rx_crc_q[CRC_W-2:0], ctrl.bit_in};
   assign crc_match   = (rx_crc_next == crc_q);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (ctrl.start) begin
         state_d = StShift;
      end else begin
         unique case (state_q)
            StIdle:   state_d = StIdle;
            StShift:  if (accept && cnt_q == LastData) state_d = StCrc;
            StCrc:    if (accept && cnt_q == LastCrc) state_d = crc_match ? StCommit : StErr;
            StCommit: state_d = StIdle;
            StErr:    state_d = StErr;
            default:  state_d = StIdle;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      bit_ready      = (state_q == StShift) || (state_q == StCrc);
      busy           = bit_ready || (state_q == StCommit);
      ctrl.bit_ready = bit_ready;
   end

   // Datapath next-state
   always_comb begin
      cnt_d        = cnt_q;
      crc_d        = crc_q;
      rx_crc_d     = rx_crc_q;
      shadow_d     = shadow_q;
      cfg_d        = cfg_q;
      done_d       = 1'b0;
      err_d        = err_q;
      cfg_loaded_d = cfg_loaded_q;
      if (ctrl.start) begin
         // Stale shadow bits are left in place; the new load overwrites them in order.
         cnt_d    = '0;
         crc_d    = '0;
         rx_crc_d = '0;
         err_d    = 1'b0;
      end else begin
         unique case (state_q)
            StShift: begin
               if (accept) begin
                  shadow_d[cnt_q] = ctrl.bit_in;
                  crc_d = {crc_q[CRC_W-2:0], 1'b0} ^
                          ((crc_q[CRC_W-1] ^ ctrl.bit_in) ? CrcPoly : '0);
                  cnt_d = (cnt_q == LastData) ? '0 : cnt_q + 10'd1;
               end
            end
            StCrc: begin
               // crc_q is frozen here; only the received trailer shifts.
               if (accept) begin
                  rx_crc_d = rx_crc_next;
                  cnt_d    = (cnt_q == LastCrc) ? '0 : cnt_q + 10'd1;
                  if (cnt_q == LastCrc && !crc_match) err_d = 1'b1;
               end
            end
            StCommit: begin
               cfg_d        = shadow_q;
               done_d       = 1'b1;
               cfg_loaded_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q        <= '0;
         crc_q        <= '0;
         rx_crc_q     <= '0;
         shadow_q     <= '0;
         cfg_q        <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         cfg_loaded_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         crc_q        <= crc_d;
         rx_crc_q     <= rx_crc_d;
         shadow_q     <= shadow_d;
         cfg_q        <= cfg_d;
         done_q       <= done_d;
         err_q        <= err_d;
         cfg_loaded_q <= cfg_loaded_d;
      end
   end

   assign done                 = done_q;
   assign err                  = err_q;
   assign cfg_loaded           = cfg_loaded_q;
   assign BLE_dff_select       = cfg_q[8:0];
   assign IO_sel               = cfg_q[12:9];
   assign IO_in                = cfg_q[32:13];
   assign LUT_in               = cfg_q[176:33];
   assign SB_in                = cfg_q[416:177];
   assign CB_in                = cfg_q[836:417];
   assign sel_direction_BLEout = cfg_q[872:837];
   assign sel_direction        = cfg_q[890:873];

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed bench for fpga_config_loader: reset, all-zero load, bad CRC, a one-hot field
// mapping table, abort (mid-shift and in commit), throttled load with reset mid-stream.
module tb_fpga_config_loader;

   logic clk = 1'b0;
   logic reset;
   logic busy, done, err, cfg_loaded;
   logic [8:0]   BLE_dff_select;
   logic [3:0]   IO_sel;
   logic [19:0]  IO_in;
   logic [143:0] LUT_in;
   logic [239:0] SB_in;
   logic [419:0] CB_in;
   logic [35:0]  sel_direction_BLEout;
   logic [17:0]  sel_direction;

   fpga_config_loader_if bus ();

   fpga_config_loader dut (
      .clk                  (clk),
      .reset                (reset),
      .ctrl                 (bus),
      .busy                 (busy),
      .done                 (done),
      .err                  (err),
      .cfg_loaded           (cfg_loaded),
      .BLE_dff_select       (BLE_dff_select),
      .IO_sel               (IO_sel),
      .IO_in                (IO_in),
      .LUT_in               (LUT_in),
      .SB_in                (SB_in),
      .CB_in                (CB_in),
      .sel_direction_BLEout (sel_direction_BLEout),
      .sel_direction        (sel_direction)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int sbit;   // stream bit set to 1
      int fld;    // expected field id
      int fbit;   // expected bit inside that field
   } vec_t;

   vec_t tbl [16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [419:0] act, input logic [419:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // Reference CRC-8, poly 0x07, init 0, stream order bit 0 first.
   function automatic logic [7:0] crc8(input logic [890:0] p);
      logic [7:0] c = 8'h00;
      logic fb;
      for (int i = 0; i < 891; i++) begin
         fb = c[7] ^ p[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   function automatic logic [898:0] mk_stream(input logic [890:0] p, input logic [7:0] c);
      logic [898:0] s;
      s[890:0] = p;
      for (int j = 0; j < 8; j++) s[891 + j] = c[7 - j];
      return s;
   endfunction

   function automatic logic [419:0] field_val(input int f);
      case (f)
         0:       return 420'(BLE_dff_select);
         1:       return 420'(IO_sel);
         2:       return 420'(IO_in);
         3:       return 420'(LUT_in);
         4:       return 420'(SB_in);
         5:       return CB_in;
         6:       return 420'(sel_direction_BLEout);
         default: return 420'(sel_direction);
      endcase
   endfunction

   task automatic check_fields(input string nm, input logic [890:0] e);
      chk({nm, ".BLE_dff_select"}, 420'(BLE_dff_select), 420'(e[8:0]));
      chk({nm, ".IO_sel"}, 420'(IO_sel), 420'(e[12:9]));
      chk({nm, ".IO_in"}, 420'(IO_in), 420'(e[32:13]));
      chk({nm, ".LUT_in"}, 420'(LUT_in), 420'(e[176:33]));
      chk({nm, ".SB_in"}, 420'(SB_in), 420'(e[416:177]));
      chk({nm, ".CB_in"}, CB_in, e[836:417]);
      chk({nm, ".sel_direction_BLEout"}, 420'(sel_direction_BLEout), 420'(e[872:837]));
      chk({nm, ".sel_direction"}, 420'(sel_direction), 420'(e[890:873]));
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Sends stream bits [first, last), with gap_pct percent chance of idle cycles before each.
   task automatic send_bits(input logic [898:0] s, input int first, input int last,
                            input int gap_pct);
      for (int k = first; k < last; k++) begin
         while ($urandom_range(99) < gap_pct) begin
            bus.bit_valid = 1'b0;
            bus.bit_in    = $urandom_range(1);
            tick();
         end
         bus.bit_valid = 1'b1;
         bus.bit_in    = s[k];
         tick();
      end
      bus.bit_valid = 1'b0;
   endtask

   task automatic full_load(input logic [890:0] p, input logic [7:0] c, input int gap_pct);
      pulse_start();
      send_bits(mk_stream(p, c), 0, 899, gap_pct);
   endtask

   // Called right after the edge that took the last CRC bit.
   task automatic check_commit(input string nm, input logic [890:0] e);
      chk1({nm, ".done_early"}, done, 1'b0);
      chk1({nm, ".busy_commit"}, busy, 1'b1);
      tick();
      chk1({nm, ".done"}, done, 1'b1);
      chk1({nm, ".cfg_loaded"}, cfg_loaded, 1'b1);
      chk1({nm, ".err"}, err, 1'b0);
      check_fields(nm, e);
      tick();
      chk1({nm, ".done_width"}, done, 1'b0);
      chk1({nm, ".busy_idle"}, busy, 1'b0);
   endtask

   function automatic logic [890:0] onehot(input int b);
      logic [890:0] v = '0;
      v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [890:0] rand_payload();
      logic [890:0] v;
      for (int i = 0; i < 891; i++) v[i] = 1'($urandom_range(1));
      return v;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [890:0] zero = '0;
      logic [890:0] pa, pb, pc, pd, pe;
      logic [419:0] one = 420'd1;

      tbl[0]  = '{0,   0, 0};   tbl[1]  = '{8,   0, 8};
      tbl[2]  = '{9,   1, 0};   tbl[3]  = '{12,  1, 3};
      tbl[4]  = '{13,  2, 0};   tbl[5]  = '{32,  2, 19};
      tbl[6]  = '{33,  3, 0};   tbl[7]  = '{176, 3, 143};
      tbl[8]  = '{177, 4, 0};   tbl[9]  = '{416, 4, 239};
      tbl[10] = '{417, 5, 0};   tbl[11] = '{836, 5, 419};
      tbl[12] = '{837, 6, 0};   tbl[13] = '{872, 6, 35};
      tbl[14] = '{873, 7, 0};   tbl[15] = '{890, 7, 17};

      bus.start = 1'b0;
      bus.bit_in = 1'b0;
      bus.bit_valid = 1'b0;

      // T1 reset
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      chk1("rst.bit_ready", bus.bit_ready, 1'b0);
      chk1("rst.busy", busy, 1'b0);
      chk1("rst.done", done, 1'b0);
      chk1("rst.err", err, 1'b0);
      chk1("rst.cfg_loaded", cfg_loaded, 1'b0);
      check_fields("rst", zero);

      // T2 all-zero load
      pulse_start();
      chk1("t2.bit_ready", bus.bit_ready, 1'b1);
      chk1("t2.busy", busy, 1'b1);
      send_bits(mk_stream(zero, 8'h00), 0, 899, 0);
      check_commit("t2", zero);

      // bit_valid in IDLE is ignored
      bus.bit_valid = 1'b1;
      bus.bit_in = 1'b1;
      tick();
      tick();
      bus.bit_valid = 1'b0;
      chk1("idle.bit_ready", bus.bit_ready, 1'b0);
      chk1("idle.busy", busy, 1'b0);

      // T3 bad CRC
      full_load(onehot(0), 8'h00, 0);
      chk1("t3.err", err, 1'b1);
      chk1("t3.done0", done, 1'b0);
      tick();
      chk1("t3.done1", done, 1'b0);
      chk1("t3.busy", busy, 1'b0);
      chk1("t3.err_held", err, 1'b1);
      tick();
      chk1("t3.done2", done, 1'b0);
      chk("t3.BLE_dff_select", 420'(BLE_dff_select), 420'd0);
      chk1("t3.cfg_loaded", cfg_loaded, 1'b1);
      pulse_start();
      chk1("t3.err_cleared", err, 1'b0);

      // T4 one-hot field mapping
      for (int v = 0; v < 16; v++) begin
         pa = onehot(tbl[v].sbit);
         full_load(pa, crc8(pa), 0);
         tick();
         chk1($sformatf("t4[%0d].done", v), done, 1'b1);
         for (int f = 0; f < 8; f++) begin
            chk($sformatf("t4[%0d].field%0d", v, f), field_val(f),
                (f == tbl[v].fld) ? (one << tbl[v].fbit) : 420'd0);
         end
         tick();
      end

      // T5 abort mid-shift: start with bit_valid drops that bit
      pa = onehot(33);
      full_load(pa, crc8(pa), 0);
      check_commit("t5a", pa);
      pb = rand_payload();
      pulse_start();
      send_bits(mk_stream(pb, crc8(pb)), 0, 500, 0);
      bus.start = 1'b1;
      bus.bit_valid = 1'b1;
      bus.bit_in = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.bit_valid = 1'b0;
      chk1("t5.busy_after_abort", busy, 1'b1);
      check_fields("t5.held", pa);
      send_bits(mk_stream(pb, crc8(pb)), 0, 899, 0);
      check_fields("t5.held_in_commit", pa);
      check_commit("t5b", pb);

      // start while in COMMIT cancels the commit
      pc = rand_payload();
      full_load(pc, crc8(pc), 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk1("t5c.done", done, 1'b0);
      chk1("t5c.busy", busy, 1'b1);
      check_fields("t5c.held", pb);
      send_bits(mk_stream(pc, crc8(pc)), 0, 899, 0);
      check_commit("t5c", pc);

      // T6 throttled load, reset at bit 700, then throttled reload
      pd = rand_payload();
      pulse_start();
      send_bits(mk_stream(pd, crc8(pd)), 0, 700, 30);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check_fields("t6.rst", zero);
      chk1("t6.cfg_loaded", cfg_loaded, 1'b0);
      chk1("t6.busy", busy, 1'b0);
      chk1("t6.bit_ready", bus.bit_ready, 1'b0);
      pe = rand_payload();
      full_load(pe, crc8(pe), 30);
      check_commit("t6", pe);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
